blink_period_meter: RTL



---
 rtl/blink_period_meter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/blink_period_meter.sv
// Measures period and high time of an asynchronous square wave, with timeout and lock status.
// Optional period min/max tracking is enabled by defining BLINK_MINMAX_EN.
module blink_period_meter #(
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             overflow,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
);

    typedef enum logic [1:0] {IDLE, FIRST, MEAS} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   pv_q, pv_d;
    logic                   locked_q, locked_d;
    logic                   ovf_q, ovf_d;
    logic                   s, rise, fall;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

`ifdef BLINK_MINMAX_EN
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
`endif

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_d_d    = s;
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        high_d   = high_q;
        pv_d     = 1'b0;
        locked_d = locked_q;
        ovf_d    = ovf_q;
`ifdef BLINK_MINMAX_EN
        min_d    = min_q;
        max_d    = max_q;
`endif
        // clr leaves the synchroniser and edge-delay flop running so a pending edge is consumed
        if (clr) begin
            state_d  = IDLE;
            cnt_d    = '0;
            period_d = '0;
            high_d   = '0;
            locked_d = 1'b0;
            ovf_d    = 1'b0;
`ifdef BLINK_MINMAX_EN
            min_d    = '0;
            max_d    = '0;
`endif
        end else begin
            if (rise)
                cnt_d = CNT_ONE;
            else if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + CNT_ONE;

            unique case (state_q)
                IDLE: begin
                    if (rise)
                        state_d = FIRST;
                end
                FIRST, MEAS: begin
                    if (rise) begin
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        locked_d = 1'b1;
                        state_d  = MEAS;
`ifdef BLINK_MINMAX_EN
                        if (state_q == FIRST || cnt_q < min_q)
                            min_d = cnt_q;
                        if (state_q == FIRST || cnt_q > max_q)
                            max_d = cnt_q;
`endif
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = IDLE;
                    end
                    if (fall)
                        high_d = cnt_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            s_d_q    <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef BLINK_MINMAX_EN
            min_q    <= '0;
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            s_d_q    <= s_d_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
`ifdef BLINK_MINMAX_EN
            min_q    <= min_d;
            max_q    <= max_d;
`endif
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign overflow     = ovf_q;

`ifdef BLINK_MINMAX_EN
    assign period_min = min_q;
    assign period_max = max_q;
`else
    assign period_min = '0;
    assign period_max = '0;
`endif

endmodule
